// File: rtl/cnt_phase_chk.sv
// -----------------------------------------------------------------------------
// cnt_phase_chk
//
// Watches the 2-bit phase counter of an upstream divider and checks that it
// advances by exactly +1 (mod 4). A SEARCH/TRACK/LOCKED state machine tracks
// whether the counter is stepping correctly, and the block keeps running counts
// of good steps and of errors.
//
// Optional feature: define CNT_PHASE_CHK_TIMEOUT_EN to add a stall watchdog.
// It drops lock after TIMEOUT cycles in LOCKED with no input change. Without
// the macro there is no stall counter and LOCKED holds indefinitely.
//
// Parameters
//   LOCK_CNT : consecutive valid steps needed to reach LOCKED (1..15)
//   ERR_MAX  : consecutive invalid steps in LOCKED that drop lock (1..15)
//   TIMEOUT  : stall limit in clk cycles (only with CNT_PHASE_CHK_TIMEOUT_EN)
//
// Ports
//   clk        : clock
//   rst        : synchronous, active-high reset
//   in_cnt     : phase counter from the divider, synchronous to clk
//   clr        : synchronous clear of step_cnt / err_cnt
//   step_pulse : one-cycle pulse per valid step
//   wrap_pulse : one-cycle pulse per valid 3->0 step
//   err_pulse  : one-cycle pulse per invalid step (or stall timeout)
//   locked     : high while the FSM is in LOCKED (one cycle behind state)
//   step_cnt   : valid-step count, wraps at 16 bits
//   err_cnt    : error count, saturates at 8'hFF
//
// Latency: an in_cnt edge at the port shows on the pulses and counters
// 3 clk cycles later; locked follows the FSM state one cycle after that.
// -----------------------------------------------------------------------------
module cnt_phase_chk #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_MAX  = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_cnt,
    input  logic        clr,
    output logic        step_pulse,
    output logic        wrap_pulse,
    output logic        err_pulse,
    output logic        locked,
    output logic [15:0] step_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_C  = 4'(ERR_MAX);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]  r_in_q_p0;
    logic [1:0]  r_prev_q_p0;
    logic        w_chg;
    logic        w_step;
    logic        w_wrap;
    logic        w_bad;

    logic        r_step_p1;
    logic        r_wrap_p1;
    logic        r_bad_p1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_gcnt;
    logic [3:0]  w_gcnt_nxt;
    logic [3:0]  r_bcnt;
    logic [3:0]  w_bcnt_nxt;
    logic        w_timeout;
    logic        w_err_evt;

    logic        r_step_pulse_p2;
    logic        r_wrap_pulse_p2;
    logic        r_err_pulse_p2;
    logic        r_locked_p2;
    logic [15:0] r_step_cnt_p2;
    logic [7:0]  r_err_cnt_p2;

    // ---- stage 0: sample the port, keep the previous sample ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q_p0   <= 2'd0;
            r_prev_q_p0 <= 2'd0;
        end else begin
            r_in_q_p0   <= in_cnt;
            r_prev_q_p0 <= r_in_q_p0;
        end
    end

    // The +1 is evaluated in 2 bits, so 3->0 counts as a valid step.
    assign w_chg  = (r_in_q_p0 != r_prev_q_p0);
    assign w_step = (r_in_q_p0 == (r_prev_q_p0 + 2'd1));
    assign w_wrap = w_step && (r_prev_q_p0 == 2'd3);
    assign w_bad  = w_chg && !w_step;

    // ---- stage 1: registered step classification ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_p1 <= 1'b0;
            r_wrap_p1 <= 1'b0;
            r_bad_p1  <= 1'b0;
        end else begin
            r_step_p1 <= w_step;
            r_wrap_p1 <= w_wrap;
            r_bad_p1  <= w_bad;
        end
    end

`ifdef CNT_PHASE_CHK_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    logic [STALL_W-1:0] r_stall;
    logic               w_nochg;

    // step and bad are mutually exclusive; neither set means no change.
    assign w_nochg   = !(r_step_p1 || r_bad_p1);
    // Fires on the TIMEOUT-th consecutive stalled cycle in LOCKED.
    assign w_timeout = (r_state == ST_LOCKED) && w_nochg && (r_stall == STALL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == ST_LOCKED) && w_nochg && !w_timeout) begin
            r_stall <= r_stall + STALL_W'(1);
        end else begin
            r_stall <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_err_evt = r_bad_p1 || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_bcnt_nxt  = r_bcnt;
        case (r_state)
            ST_SEARCH: begin
                if (r_step_p1) begin
                    w_gcnt_nxt = 4'd1;
                    if (LOCK_C == 4'd1) begin
                        w_state_nxt = ST_LOCKED;
                        w_bcnt_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (r_step_p1) begin
                    w_gcnt_nxt = r_gcnt + 4'd1;
                    if ((r_gcnt + 4'd1) == LOCK_C) begin
                        w_state_nxt = ST_LOCKED;
                        w_bcnt_nxt  = 4'd0;
                    end
                end else if (r_bad_p1) begin
                    w_state_nxt = ST_SEARCH;
                    w_gcnt_nxt  = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEARCH;
                    w_gcnt_nxt  = 4'd0;
                    w_bcnt_nxt  = 4'd0;
                end else if (r_step_p1) begin
                    w_bcnt_nxt = 4'd0;
                end else if (r_bad_p1) begin
                    if ((r_bcnt + 4'd1) == ERR_C) begin
                        w_state_nxt = ST_SEARCH;
                        w_gcnt_nxt  = 4'd0;
                        w_bcnt_nxt  = 4'd0;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_gcnt_nxt  = 4'd0;
                w_bcnt_nxt  = 4'd0;
            end
        endcase
    end

    // ---- stage 2: FSM state, pulses and statistics ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_SEARCH;
            r_gcnt          <= 4'd0;
            r_bcnt          <= 4'd0;
            r_step_pulse_p2 <= 1'b0;
            r_wrap_pulse_p2 <= 1'b0;
            r_err_pulse_p2  <= 1'b0;
            r_locked_p2     <= 1'b0;
            r_step_cnt_p2   <= 16'd0;
            r_err_cnt_p2    <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_gcnt          <= w_gcnt_nxt;
            r_bcnt          <= w_bcnt_nxt;
            r_step_pulse_p2 <= r_step_p1;
            r_wrap_pulse_p2 <= r_wrap_p1;
            r_err_pulse_p2  <= w_err_evt;
            // Follows the state register, so locked lags state by one cycle.
            r_locked_p2     <= (r_state == ST_LOCKED);
            // clr wins over a same-cycle increment.
            if (clr) begin
                r_step_cnt_p2 <= 16'd0;
                r_err_cnt_p2  <= 8'd0;
            end else begin
                if (r_step_p1) begin
                    r_step_cnt_p2 <= r_step_cnt_p2 + 16'd1;
                end
                if (w_err_evt) begin
                    r_err_cnt_p2 <= sat_inc8(r_err_cnt_p2);
                end
            end
        end
    end

    assign step_pulse = r_step_pulse_p2;
    assign wrap_pulse = r_wrap_pulse_p2;
    assign err_pulse  = r_err_pulse_p2;
    assign locked     = r_locked_p2;
    assign step_cnt   = r_step_cnt_p2;
    assign err_cnt    = r_err_cnt_p2;

endmodule

// File: tb/tb_cnt_phase_chk.sv
// -----------------------------------------------------------------------------
// tb_cnt_phase_chk
//
// Self-checking bench for cnt_phase_chk. A reference model runs alongside the
// stimulus: each driven value becomes an event, and the expected outputs are
// queued and compared cycle by cycle. A table of single transitions, plus
// directed sequences for lock, loss of lock, clear, reset, saturation and stall
// behaviour, check against hand-derived values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnt_phase_chk;

    localparam int LOCK_CNT = 4;
    localparam int ERR_MAX  = 3;
    localparam int TIMEOUT  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  in_cnt = 2'd0;
    logic        step_pulse;
    logic        wrap_pulse;
    logic        err_pulse;
    logic        locked;
    logic [15:0] step_cnt;
    logic [7:0]  err_cnt;

    cnt_phase_chk #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_MAX  (ERR_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_cnt     (in_cnt),
        .clr        (clr),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .locked     (locked),
        .step_cnt   (step_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic chg;
        logic step;
        logic wrap;
        logic bad;
    } ev_t;

    typedef struct {
        logic        step;
        logic        wrap;
        logic        err;
        logic        lck;
        logic [15:0] sc;
        logic [7:0]  ec;
    } exp_t;

    typedef struct {
        logic [1:0] p;
        logic [1:0] v;
        logic       st;
        logic       wr;
        logic       er;
    } vec_t;

    ev_t  ev_q[$];
    exp_t exp_q[$];
    vec_t tbl[16];

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int         m_state;   // 0 SEARCH, 1 TRACK, 2 LOCKED
    int         m_g;
    int         m_b;
    int         m_stall;
    int         m_sc;
    int         m_ec;
    logic [1:0] m_prev;

    // observation bookkeeping
    int   cyc_no = 0;
    int   n_step_seen, n_wrap_seen, n_err_seen;
    int   step4_cyc, lock_cyc, last_step_cyc, err_cyc;
    bit   lock_seen;
    logic s_step, s_wrap, s_err;
    logic [1:0] cur;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic ev_t make_ev(input logic [1:0] p, input logic [1:0] v);
        ev_t e;
        int  d;
        d = (int'(v) - int'(p) + 4) % 4;
        e.chg  = (d != 0);
        e.step = (d == 1);
        e.wrap = (d == 1) && (p == 2'd3);
        e.bad  = (d == 2) || (d == 3);
        return e;
    endfunction

    task automatic clear_obs();
        n_step_seen = 0; n_wrap_seen = 0; n_err_seen = 0;
        step4_cyc = -1; lock_cyc = -1; last_step_cyc = -1; err_cyc = -1;
        lock_seen = 0;
    endtask

    // Drive one input value and advance the model by the event that the DUT
    // commits at the next clock edge (the one driven two iterations earlier).
    task automatic drive_and_model(input logic [1:0] v, input logic c);
        ev_t  e;
        ev_t  pe;
        exp_t x;
        bit   to;
        in_cnt = v;
        clr    = c;
        e = make_ev(m_prev, v);
        m_prev = v;
        ev_q.push_back(e);
        pe = ev_q.pop_front();
        x.lck = (m_state == 2);
        to = 0;
`ifdef CNT_PHASE_CHK_TIMEOUT_EN
        if (m_state == 2 && !pe.chg) begin
            if (m_stall == TIMEOUT - 1) begin
                to = 1;
                m_stall = 0;
            end else begin
                m_stall++;
            end
        end else begin
            m_stall = 0;
        end
`endif
        x.step = pe.step;
        x.wrap = pe.wrap;
        x.err  = pe.bad | to;
        if (c) begin
            m_sc = 0;
            m_ec = 0;
        end else begin
            if (pe.step) m_sc = (m_sc + 1) % 65536;
            if (x.err && m_ec < 255) m_ec++;
        end
        case (m_state)
            0: if (pe.step) begin
                   m_g = 1;
                   if (LOCK_CNT == 1) begin m_state = 2; m_b = 0; end
                   else m_state = 1;
               end
            1: if (pe.step) begin
                   m_g++;
                   if (m_g == LOCK_CNT) begin m_state = 2; m_b = 0; end
               end else if (pe.bad) begin
                   m_state = 0; m_g = 0;
               end
            default: if (to) begin
                   m_state = 0; m_g = 0; m_b = 0;
               end else if (pe.step) begin
                   m_b = 0;
               end else if (pe.bad) begin
                   m_b++;
                   if (m_b == ERR_MAX) begin m_state = 0; m_g = 0; m_b = 0; end
               end
        endcase
        x.sc = 16'(m_sc);
        x.ec = 8'(m_ec);
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic [1:0] v, input logic c);
        exp_t x;
        @(posedge clk); #1;
        cyc_no++;
        s_step = step_pulse; s_wrap = wrap_pulse; s_err = err_pulse;
        if (step_pulse) begin
            n_step_seen++;
            last_step_cyc = cyc_no;
            if (n_step_seen == 4) step4_cyc = cyc_no;
        end
        if (wrap_pulse) n_wrap_seen++;
        if (err_pulse) begin n_err_seen++; err_cyc = cyc_no; end
        if (locked && !lock_seen) begin lock_seen = 1; lock_cyc = cyc_no; end
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_chk++;
            if (step_pulse === x.step && wrap_pulse === x.wrap && err_pulse === x.err &&
                locked === x.lck && step_cnt === x.sc && err_cnt === x.ec) begin
                n_pass++;
            end else begin
                $display("FAIL sb cyc %0d: got step=%b wrap=%b err=%b lck=%b sc=%0d ec=%0d expected step=%b wrap=%b err=%b lck=%b sc=%0d ec=%0d",
                         cyc_no, step_pulse, wrap_pulse, err_pulse, locked, step_cnt, err_cnt,
                         x.step, x.wrap, x.err, x.lck, x.sc, x.ec);
            end
        end
        drive_and_model(v, c);
        cur = v;
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0);
    endtask

    task automatic do_reset();
        ev_t z;
        z = '{chg: 1'b0, step: 1'b0, wrap: 1'b0, bad: 1'b0};
        @(posedge clk); #1; cyc_no++;
        rst = 1'b1; in_cnt = 2'd0; clr = 1'b1;
        exp_q.delete();
        ev_q.delete();
        @(posedge clk); #1; cyc_no++;
        chk("rst_outs", {step_pulse, wrap_pulse, err_pulse, locked, step_cnt, err_cnt}, 0);
        @(posedge clk); #1; cyc_no++;
        rst = 1'b0;
        m_state = 0; m_g = 0; m_b = 0; m_stall = 0; m_sc = 0; m_ec = 0; m_prev = 2'd0;
        ev_q.push_back(z);
        ev_q.push_back(z);
        drive_and_model(2'd0, 1'b0);
        cur = 2'd0;
        clear_obs();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // prev, next, step, wrap, err
        tbl[0]  = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 2'd3, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{2'd2, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{2'd3, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{2'd3, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{2'd3, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{2'd3, 2'd3, 1'b0, 1'b0, 1'b0};

        do_reset();

        // single transitions, 3-cycle pulse latency
        for (int i = 0; i < 16; i++) begin
            do_reset();
            hold(tbl[i].p, 4);
            cyc(tbl[i].v, 1'b0);
            hold(tbl[i].v, 3);
            chk($sformatf("tbl_%0d_to_%0d", tbl[i].p, tbl[i].v),
                {s_step, s_wrap, s_err}, {tbl[i].st, tbl[i].wr, tbl[i].er});
        end

        // first sample of 1 after reset is a valid step
        do_reset();
        hold(2'd1, 4);
        chk("first_sample_step", step_cnt, 1);
        chk("first_sample_err", err_cnt, 0);

        // lock acquisition with 8 steps every 4 cycles
        do_reset();
        for (int k = 0; k < 8; k++) hold(2'((k + 1) % 4), 4);
        hold(cur, 4);
        chk("acq_steps_seen", n_step_seen, 8);
        chk("acq_wraps_seen", n_wrap_seen, 2);
        chk("acq_lock_timing", lock_cyc, step4_cyc + 1);
        chk("acq_step_cnt", step_cnt, 8);
        chk("acq_locked", locked, 1);
        chk("acq_err_cnt", err_cnt, 0);

        // one 1->3 jump while locked, then valid steps resume
        clear_obs();
        hold(2'd1, 4);
        hold(2'd3, 4);
        hold(2'd0, 4);
        hold(2'd1, 4);
        hold(2'd2, 4);
        chk("jump_err_seen", n_err_seen, 1);
        chk("jump_err_cnt", err_cnt, 1);
        chk("jump_locked", locked, 1);
        // two more back-to-back errors stay below ERR_MAX only if bcnt cleared
        hold(2'd0, 4);
        hold(2'd2, 4);
        hold(2'd3, 4);
        hold(2'd3, 4);
        chk("bcnt_cleared_locked", locked, 1);
        chk("bcnt_cleared_err_cnt", err_cnt, 3);

        // three consecutive errors drop lock, four steps regain it
        do_reset();
        hold(2'd1, 4); hold(2'd2, 4); hold(2'd3, 4); hold(2'd0, 4);
        hold(2'd2, 4); hold(2'd0, 4); hold(2'd2, 4);
        hold(2'd2, 3);
        chk("loss_err_cnt", err_cnt, 3);
        chk("loss_locked", locked, 0);
        hold(2'd3, 4); hold(2'd0, 4); hold(2'd1, 4); hold(2'd2, 4);
        hold(2'd2, 2);
        chk("relock_locked", locked, 1);

        // clr in the same cycle as the increment from 5
        do_reset();
        hold(2'd1, 4); hold(2'd2, 4); hold(2'd3, 4); hold(2'd0, 4); hold(2'd1, 4);
        chk("clr_pre_step_cnt", step_cnt, 5);
        cyc(2'd2, 1'b0);
        cyc(2'd2, 1'b0);
        cyc(2'd2, 1'b1);
        cyc(2'd2, 1'b0);
        chk("clr_step_pulse", s_step, 1);
        chk("clr_step_cnt", step_cnt, 0);
        chk("clr_locked", locked, 1);

        // 100 steps at one per cycle, then a one-cycle reset pulse
        hold(2'd2, 2);
        for (int k = 0; k < 100; k++) cyc(cur + 2'd1, 1'b0);
        hold(cur, 4);
        chk("pre_rst_step_cnt", step_cnt, 100);
        chk("pre_rst_locked", locked, 1);
        do_reset();

        // err_cnt saturation and clear
        for (int k = 0; k < 300; k++) cyc(cur + 2'd2, 1'b0);
        hold(cur, 4);
        chk("err_sat", err_cnt, 255);
        cyc(cur, 1'b1);
        cyc(cur, 1'b0);
        chk("err_clr", err_cnt, 0);

        // input frozen while locked
        do_reset();
        hold(2'd1, 4); hold(2'd2, 4); hold(2'd3, 4); hold(2'd0, 4);
        clear_obs();
`ifdef CNT_PHASE_CHK_TIMEOUT_EN
        hold(2'd0, 20);
        chk("tmo_err_seen", n_err_seen, 1);
        chk("tmo_locked", locked, 0);
        chk("tmo_err_cnt", err_cnt, 1);
`else
        hold(2'd0, 1000);
        chk("stall_locked", locked, 1);
        chk("stall_err_cnt", err_cnt, 0);
        chk("stall_err_seen", n_err_seen, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cnt_phase_chk.md
CNT_PHASE_CHK -- requirements
Module: cnt_phase_chk

Interface
REQ-001 SHALL have these parameters, one per line: name, default, meaning.
- LOCK_CNT, 4, number of consecutive valid steps needed to declare lock (range 1..15).
- ERR_MAX, 3, number of consecutive invalid steps in LOCKED that force loss of lock (range 1..15).
- TIMEOUT, 8, stall limit in clk cycles (used only with the macro in REQ-020).

REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high; clock clk.
- in_cnt, in, 2, phase counter from the upstream divider stage, synchronous to clk.
- clr, in, 1, synchronous clear of the statistics counters.
- step_pulse, out, 1, one-cycle pulse per valid step.
- wrap_pulse, out, 1, one-cycle pulse per valid 3->0 step.
- err_pulse, out, 1, one-cycle pulse per invalid step (or timeout).
- locked, out, 1, high while the FSM is in LOCKED.
- step_cnt, out, 16, valid-step count.
- err_cnt, out, 8, error count.

Function
REQ-003 SHALL register in_cnt into in_q every cycle, and in_q into prev_q every cycle.
REQ-004 SHALL detect a change as in_q != prev_q.
- Valid step: in_q == prev_q + 1 (mod 4).
- Invalid step: any other change (a +2 or +3 jump).
- No change: neither valid nor invalid.
REQ-005 SHALL assert step_pulse, wrap_pulse and err_pulse as registered outputs, 3 clk cycles after the in_cnt edge at the port; each pulse SHALL last exactly one cycle per event.
REQ-006 SHALL assert wrap_pulse only together with step_pulse, and only when prev_q==3 and in_q==0.
REQ-007 SHALL implement an FSM with states SEARCH, TRACK and LOCKED, with a 4-bit good-step counter gcnt and a 4-bit consecutive-bad counter bcnt.
REQ-008 SEARCH:
- Valid step -> TRACK with gcnt=1; if LOCK_CNT==1, go directly to LOCKED instead.
- Invalid step or no change -> stay in SEARCH.
REQ-009 TRACK:
- Valid step: gcnt+1; when gcnt+1 == LOCK_CNT -> LOCKED, with bcnt=0.
- Invalid step -> SEARCH with gcnt=0.
- No change -> hold.
REQ-010 LOCKED:
- Valid step -> bcnt=0.
- Invalid step -> bcnt+1; when bcnt+1 == ERR_MAX -> SEARCH with gcnt=0 and bcnt=0.
REQ-011 SHALL drive locked as a registered output, high in the cycle after the FSM enters LOCKED and low in the cycle after it leaves.
REQ-012 SHALL increment step_cnt on every valid step in every state; it SHALL wrap from 16'hFFFF to 0.
REQ-013 SHALL increment err_cnt on every invalid step in every state (and on timeout, REQ-020); it SHALL saturate at 8'hFF.
REQ-014 SHALL give clr priority over a simultaneous increment: both counters read 0 the next cycle. clr SHALL NOT affect the FSM, gcnt, bcnt or the pulse outputs.
REQ-015 SHALL keep prev_q at 0 after reset, so a first sample of in_q==1 counts as a valid step and a first sample of 2 or 3 counts as invalid.

Reset
REQ-016 SHALL, while rst is high at a clk edge, set in_q=0, prev_q=0, state=SEARCH, gcnt=0, bcnt=0 and the stall counter to 0.
REQ-017 SHALL hold outputs at reset: step_pulse=0, wrap_pulse=0, err_pulse=0, locked=0, step_cnt=0, err_cnt=0.
REQ-018 SHALL let rst override clr and all in-flight events; reset asserted mid-LOCKED SHALL deassert locked on the next cycle.
REQ-019 SHALL take its first sample of in_cnt in the cycle after rst deasserts.

Configuration
REQ-020 With CNT_PHASE_CHK_TIMEOUT_EN defined:
- A stall counter SHALL count cycles with no change while in LOCKED, and clear on any change or on leaving LOCKED.
- When the count reaches TIMEOUT: one err_pulse, err_cnt+1 (saturating), and the FSM goes to SEARCH with gcnt=0 and bcnt=0.
REQ-021 Without CNT_PHASE_CHK_TIMEOUT_EN: no stall counter SHALL be synthesised, and LOCKED SHALL persist indefinitely without input changes.

Verification
REQ-022 in_cnt stepping 0,1,2,3,0,... once every 4 cycles after reset, LOCK_CNT=4 -> locked=1 one cycle after the 4th step_pulse; wrap_pulse on each 3->0; step_cnt=8 after 8 steps.
REQ-023 Locked, in_cnt jump 1->3 once, then valid steps resume -> one err_pulse; err_cnt=1; locked stays 1; bcnt returns to 0.
REQ-024 Locked, ERR_MAX=3, three consecutive invalid jumps -> err_cnt=3; locked=0 after the 3rd; after 4 further valid steps, locked=1 again.
REQ-025 clr asserted in the same cycle as a step_pulse-causing increment, with step_cnt=5 -> step_cnt=0 next cycle; locked unchanged.
REQ-026 rst pulsed for 1 cycle while locked with step_cnt=100 -> next cycle: locked=0, step_cnt=0, err_cnt=0, all pulses 0.
REQ-027 With CNT_PHASE_CHK_TIMEOUT_EN and TIMEOUT=8, in_cnt frozen while locked -> err_pulse and locked=0 after 8 stall cycles. Without the macro -> locked stays 1 for 1000 cycles.
